// File: rtl/slot_game_ctrl_pkg.sv
// Shared definitions for the slot machine game sequencer: state encoding and default widths.
package slot_game_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPIN    = 2'd1,
        S_EVAL    = 2'd2,
        S_CASHOUT = 2'd3
    } state_t;

    localparam int DEF_CREDIT_W = 8;
    localparam int DEF_BET      = 1;
    localparam int DEF_NREEL    = 9;

endpackage

// File: rtl/slot_edge_det.sv
// Vector rising-edge detector; one registered stage, history cleared by synchronous reset.
module slot_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] d_q;

    // History resets low so an input already high at reset release yields one edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            d_q  <= '0;
            rise <= '0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine game sequencer: credit accounting, reel spin/stop control, evaluation handshake
// and hopper cash-out.
module slot_game_ctrl
    import slot_game_ctrl_pkg::*;
#(
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int MAX_CREDIT   = 255,
    parameter int BET          = DEF_BET,
    parameter int NREEL        = DEF_NREEL,
    parameter int STOP_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                coin_in,
    input  logic                start_btn,
    input  logic                cashout_btn,
    input  logic [NREEL-1:0]    stop_btn,
    input  logic                eval_done,
    input  logic [CREDIT_W-1:0] win_amt,
    input  logic                hopper_rdy,
    output logic [NREEL-1:0]    reel_spin,
    output logic                eval_req,
    output logic                coin_out,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TMR_W = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(STOP_TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] MAX_C    = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] BET_C    = CREDIT_W'(BET);
    localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);

    // Sum is formed one bit wider so a wrap can never hide an overflow before clamping.
    function automatic logic [CREDIT_W-1:0] sat_add(
        input logic [CREDIT_W-1:0] a,
        input logic [CREDIT_W-1:0] b,
        input logic                c
    );
        logic [CREDIT_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{CREDIT_W{1'b0}}, c};
        if (s > {1'b0, MAX_C})
            return MAX_C;
        return s[CREDIT_W-1:0];
    endfunction

    logic [NREEL+2:0] rise;
    logic             coin_e;
    logic             start_e;
    logic             cash_e;
    logic [NREEL-1:0] stop_e;

    slot_edge_det #(.W(NREEL + 3)) u_edge (
        .clk  (clk),
        .clr  (clr),
        .d    ({coin_in, start_btn, cashout_btn, stop_btn}),
        .rise (rise)
    );

    assign coin_e  = rise[NREEL+2];
    assign start_e = rise[NREEL+1];
    assign cash_e  = rise[NREEL];
    assign stop_e  = rise[NREEL-1:0];

    state_t              state, state_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [NREEL-1:0]    reel_nx;
    logic                eval_req_nx;
    logic                coin_out_nx;
    logic                coin_reject_nx;
    logic                busy_nx;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            timer       <= '0;
            credit      <= '0;
            reel_spin   <= '0;
            eval_req    <= 1'b0;
            coin_out    <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            credit      <= credit_nx;
            reel_spin   <= reel_nx;
            eval_req    <= eval_req_nx;
            coin_out    <= coin_out_nx;
            coin_reject <= coin_reject_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        timer_nx       = timer;
        credit_nx      = credit;
        reel_nx        = reel_spin;
        eval_req_nx    = eval_req;
        coin_out_nx    = 1'b0;
        coin_reject_nx = 1'b0;

        // Coins are credited in every state but CASHOUT; branches below may override.
        if (coin_e && state != S_CASHOUT)
            credit_nx = sat_add(credit, '0, 1'b1);

        case (state)
            S_IDLE: begin
                if (cash_e && credit != '0) begin
                    state_nx = S_CASHOUT;
                end else if (start_e && credit >= BET_C) begin
                    credit_nx = credit - BET_C + {{(CREDIT_W-1){1'b0}}, coin_e};
                    reel_nx   = '1;
                    timer_nx  = '0;
                    state_nx  = S_SPIN;
                end
            end
            S_SPIN: begin
                timer_nx = timer + TMR_W'(1);
                if (reel_spin == '0) begin
                    eval_req_nx = 1'b1;
                    state_nx    = S_EVAL;
                end else if (timer == TMR_LAST) begin
                    reel_nx = '0;
                end else begin
                    reel_nx = reel_spin & ~stop_e;
                end
            end
            S_EVAL: begin
                if (eval_done) begin
                    credit_nx   = sat_add(credit, win_amt, coin_e);
                    eval_req_nx = 1'b0;
                    state_nx    = S_IDLE;
                end
            end
            S_CASHOUT: begin
                coin_reject_nx = coin_e;
                // Gating on coin_out keeps dispense pulses at least one idle cycle apart.
                if (hopper_rdy && credit != '0 && !coin_out) begin
                    coin_out_nx = 1'b1;
                    credit_nx   = credit - ONE_C;
                end else if (credit == '0 && !coin_out) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Scoreboard bench for slot_game_ctrl: expectations are queued with a target cycle when stimulus
// is driven and compared by a monitor on the falling edge of that cycle.
module tb_slot_game_ctrl;

    localparam int TO = 1000;

    localparam int SIG_CREDIT = 0;
    localparam int SIG_SPIN   = 1;
    localparam int SIG_BUSY   = 2;
    localparam int SIG_EVREQ  = 3;
    localparam int SIG_COUT   = 4;
    localparam int SIG_CREJ   = 5;

    typedef struct {
        string       tag;
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic       clk;
    logic       clr;
    logic       coin_in;
    logic       start_btn;
    logic       cashout_btn;
    logic [8:0] stop_btn;
    logic       eval_done;
    logic [7:0] win_amt;
    logic       hopper_rdy;
    logic [8:0] reel_spin;
    logic       eval_req;
    logic       coin_out;
    logic       coin_reject;
    logic [7:0] credit;
    logic       busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    int   pulse_cnt = 0;
    int   b2b_cnt = 0;
    logic prev_cout = 1'b0;

    slot_game_ctrl #(
        .CREDIT_W     (8),
        .MAX_CREDIT   (255),
        .BET          (1),
        .NREEL        (9),
        .STOP_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .coin_in     (coin_in),
        .start_btn   (start_btn),
        .cashout_btn (cashout_btn),
        .stop_btn    (stop_btn),
        .eval_done   (eval_done),
        .win_amt     (win_amt),
        .hopper_rdy  (hopper_rdy),
        .reel_spin   (reel_spin),
        .eval_req    (eval_req),
        .coin_out    (coin_out),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs_sig(input int s);
        case (s)
            SIG_CREDIT: return {24'd0, credit};
            SIG_SPIN:   return {23'd0, reel_spin};
            SIG_BUSY:   return {31'd0, busy};
            SIG_EVREQ:  return {31'd0, eval_req};
            SIG_COUT:   return {31'd0, coin_out};
            default:    return {31'd0, coin_reject};
        endcase
    endfunction

    task automatic push(input int k, input int s, input logic [31:0] v, input string tag);
        exp_t e;
        e.tag = tag;
        e.cyc = cyc + k;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, obs_sig(sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (coin_out) begin
            pulse_cnt++;
            if (prev_cout)
                b2b_cnt++;
        end
        prev_cout = coin_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_coin(input int exp_credit);
        coin_in = 1'b1;
        push(2, SIG_CREDIT, exp_credit, "coin_credit");
        tick();
        coin_in = 1'b0;
        tick();
    endtask

    task automatic press_stop(input int i, input logic [8:0] exp_spin);
        stop_btn = 9'd1 << i;
        push(2, SIG_SPIN, {23'd0, exp_spin}, "stop_reel");
        tick();
        stop_btn = '0;
        tick();
    endtask

    task automatic game(input logic [7:0] win, input int cr_bet, input int cr_win);
        start_btn = 1'b1;
        push(2, SIG_CREDIT, cr_bet, "game_bet");
        push(2, SIG_BUSY, 1, "game_busy");
        tick();
        start_btn = 1'b0;
        tick();
        stop_btn = '1;
        push(2, SIG_SPIN, 0, "game_stop_all");
        push(3, SIG_EVREQ, 1, "game_evreq");
        tick();
        stop_btn = '0;
        tick();
        tick();
        eval_done = 1'b1;
        win_amt   = win;
        push(1, SIG_CREDIT, cr_win, "game_win");
        push(1, SIG_EVREQ, 0, "game_evreq_drop");
        push(1, SIG_BUSY, 0, "game_idle");
        tick();
        eval_done = 1'b0;
        win_amt   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] m;
        clr = 1'b1; coin_in = 1'b0; start_btn = 1'b0; cashout_btn = 1'b0;
        stop_btn = '0; eval_done = 1'b0; win_amt = '0; hopper_rdy = 1'b0;

        tick();
        tick();
        push(0, SIG_CREDIT, 0, "rst_credit");
        push(0, SIG_SPIN,   0, "rst_spin");
        push(0, SIG_BUSY,   0, "rst_busy");
        push(0, SIG_EVREQ,  0, "rst_evreq");
        push(0, SIG_COUT,   0, "rst_cout");
        push(0, SIG_CREJ,   0, "rst_crej");
        clr = 1'b0;
        tick();

        // Three coins, then start.
        press_coin(1);
        press_coin(2);
        press_coin(3);
        start_btn = 1'b1;
        push(1, SIG_BUSY, 0, "start_lat_busy");
        push(2, SIG_CREDIT, 2, "start_credit");
        push(2, SIG_SPIN, 9'h1FF, "start_spin");
        push(2, SIG_BUSY, 1, "start_busy");
        tick();
        start_btn = 1'b0;
        tick();

        // Stop reels in order; a repeated stop on reel 0 changes nothing.
        for (int i = 0; i < 9; i++) begin
            m = 9'h1FF << (i + 1);
            press_stop(i, m);
            if (i == 1)
                press_stop(0, m);
        end
        push(0, SIG_EVREQ, 0, "evreq_before");
        push(1, SIG_EVREQ, 1, "evreq_after_last");
        tick();
        tick();
        tick();
        push(0, SIG_EVREQ, 1, "evreq_held");
        push(0, SIG_BUSY, 1, "eval_busy");
        eval_done = 1'b1;
        win_amt   = 8'd5;
        push(1, SIG_CREDIT, 7, "win5_credit");
        push(1, SIG_EVREQ, 0, "win5_evreq");
        push(1, SIG_BUSY, 0, "win5_idle");
        tick();
        eval_done = 1'b0;
        win_amt   = '0;

        // No stops: all reels released exactly TO cycles after SPIN entry.
        start_btn = 1'b1;
        push(2, SIG_CREDIT, 6, "to_credit");
        push(2 + TO - 1, SIG_SPIN, 9'h1FF, "to_spin_before");
        push(2 + TO, SIG_SPIN, 0, "to_spin_clear");
        push(2 + TO, SIG_BUSY, 1, "to_busy");
        push(2 + TO + 1, SIG_EVREQ, 1, "to_evreq");
        tick();
        start_btn = 1'b0;
        repeat (TO + 2) tick();
        eval_done = 1'b1;
        push(1, SIG_CREDIT, 6, "to_win0");
        push(1, SIG_BUSY, 0, "to_idle");
        tick();
        eval_done = 1'b0;

        // Reach 254 then saturate on win + coin in the same cycle.
        game(8'd249, 5, 254);
        start_btn = 1'b1;
        push(2, SIG_CREDIT, 253, "sat_bet");
        tick();
        start_btn = 1'b0;
        tick();
        stop_btn = '1;
        coin_in  = 1'b1;
        push(2, SIG_CREDIT, 254, "spin_coin");
        tick();
        stop_btn = '0;
        coin_in  = 1'b0;
        tick();
        tick();
        coin_in = 1'b1;
        tick();
        coin_in   = 1'b0;
        eval_done = 1'b1;
        win_amt   = 8'd10;
        push(1, SIG_CREDIT, 255, "win_sat");
        push(1, SIG_BUSY, 0, "win_sat_idle");
        tick();
        eval_done = 1'b0;
        win_amt   = '0;
        tick();
        press_coin(255);

        // Reset mid-SPIN discards credit.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        push(0, SIG_CREDIT, 0, "clr_idle_credit");
        for (int i = 1; i <= 5; i++)
            press_coin(i);
        start_btn = 1'b1;
        push(2, SIG_CREDIT, 4, "clr_bet");
        tick();
        start_btn = 1'b0;
        tick();
        tick();
        tick();
        clr = 1'b1;
        push(1, SIG_CREDIT, 0, "clr_credit");
        push(1, SIG_SPIN, 0, "clr_spin");
        push(1, SIG_BUSY, 0, "clr_busy");
        push(1, SIG_COUT, 0, "clr_cout");
        tick();
        clr = 1'b0;
        start_btn = 1'b1;
        push(2, SIG_BUSY, 0, "start_nocredit");
        push(3, SIG_BUSY, 0, "start_nocredit2");
        tick();
        start_btn = 1'b0;
        tick();
        tick();
        cashout_btn = 1'b1;
        push(2, SIG_BUSY, 0, "cash_nocredit");
        tick();
        cashout_btn = 1'b0;
        tick();
        tick();

        // Cash-out of three credits with a rejected coin and a gappy hopper.
        press_coin(1);
        press_coin(2);
        press_coin(3);
        pulse_cnt = 0;
        b2b_cnt   = 0;
        cashout_btn = 1'b1;
        push(2, SIG_BUSY, 1, "cash_busy");
        push(2, SIG_CREDIT, 3, "cash_hold");
        tick();
        cashout_btn = 1'b0;
        tick();
        coin_in = 1'b1;
        push(1, SIG_CREJ, 0, "crej_before");
        push(2, SIG_CREJ, 1, "crej_pulse");
        push(3, SIG_CREJ, 0, "crej_after");
        tick();
        coin_in = 1'b0;
        tick();
        for (int k = 0; k < 30; k++) begin
            hopper_rdy = (k % 4 != 3);
            tick();
        end
        hopper_rdy = 1'b0;
        push(0, SIG_CREDIT, 0, "cash_credit0");
        push(0, SIG_BUSY, 0, "cash_idle");
        tick();
        tick();

        chk("coin_out_pulses", pulse_cnt, 3);
        chk("coin_out_b2b", b2b_cnt, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
